// File: rtl/fdl_pkg.sv
// Shared definitions for the fine delay line controller.
//   FDL_BITS    : width of the delay control word
//   IDX_W       : width of the SAR bit index
//   FILT_W      : width of the signed tracking filter (holds +/-7, enough for FILT up to 7)
//   fdl_state_t : controller state encoding
//   sar_next()  : one SAR decision step on the control word
package fdl_pkg;

   localparam int FDL_BITS = 6;
   localparam int IDX_W    = $clog2(FDL_BITS);
   localparam int FILT_W   = 4;

   localparam logic [FDL_BITS-1:0] Q_MAX      = {FDL_BITS{1'b1}};
   localparam logic [FDL_BITS-1:0] Q_SAR_INIT = {1'b1, {(FDL_BITS-1){1'b0}}};

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SAR    = 2'd1;
   localparam logic [1:0] ST_TRACK  = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_SAR    = ST_SAR,
      S_TRACK  = ST_TRACK,
      S_LOCKED = ST_LOCKED
   } fdl_state_t;

   // Resolve bit idx (keep or clear), then arm the next lower bit as the new trial.
   function automatic logic [FDL_BITS-1:0] sar_next(input logic [FDL_BITS-1:0] q,
                                                    input logic [IDX_W-1:0]    idx,
                                                    input logic                keep);
      logic [FDL_BITS-1:0] r;
      r      = q;
      r[idx] = keep;
      if (idx != '0) r[idx - 1'b1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fdl_step_filter.sv
// Signed up/down vote filter for delay tracking.
//   clk_in  : clock
//   rst     : synchronous active-high reset
//   clr     : synchronous clear of the accumulator (priority over sample)
//   sample  : qualify up/dn in this cycle
//   up, dn  : phase detector votes; both or neither leave the accumulator unchanged
//   step_up : this sample brings the accumulator to +FILT (combinational)
//   step_dn : this sample brings the accumulator to -FILT (combinational)
module fdl_step_filter
   import fdl_pkg::*;
#(
   parameter int FILT = 3
) (
   input  logic clk_in,
   input  logic rst,
   input  logic clr,
   input  logic sample,
   input  logic up,
   input  logic dn,
   output logic step_up,
   output logic step_dn
);

   localparam logic signed [FILT_W-1:0] THR_P = FILT_W'(FILT);
   localparam logic signed [FILT_W-1:0] THR_N = -THR_P;
   localparam logic signed [FILT_W-1:0] ONE   = FILT_W'(1);

   logic signed [FILT_W-1:0] acc;
   logic signed [FILT_W-1:0] acc_nxt;

   always_comb begin
      acc_nxt = acc;
      if (up && !dn)      acc_nxt = acc + ONE;
      else if (dn && !up) acc_nxt = acc - ONE;
   end

   assign step_up = sample && (acc_nxt == THR_P);
   assign step_dn = sample && (acc_nxt == THR_N);

   always_ff @(posedge clk_in) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (sample) begin
         // a step consumes the accumulated votes
         acc <= (step_up || step_dn) ? '0 : acc_nxt;
      end
   end

endmodule

// File: rtl/fdl_ctrl.sv
// Fine delay line controller: SAR calibration followed by filtered tracking
// with lock detection and carry requests to a coarse stage.
//   clk_in   : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   en       : 1 = calibrate/track, 0 = freeze Q and idle
//   pd_up    : phase detector, increase delay
//   pd_dn    : phase detector, decrease delay
//   Q, Qb    : delay control word and its registered complement
//   lock     : high while LOCKED
//   carry_up : one-cycle request for more coarse delay (up-step at Q max)
//   carry_dn : one-cycle request for less coarse delay (down-step at Q zero)
//
// state  | meaning
// IDLE   | Q held, waiting for en
// SAR    | binary search, one bit decided per settled sample, MSB first
// TRACK  | filtered +/-1 steps, counting step-free samples toward lock
// LOCKED | as TRACK with lock high; any step or carry returns to TRACK
module fdl_ctrl
   import fdl_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int FILT       = 3,
   parameter int LOCK_CNT   = 8
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                en,
   input  logic                pd_up,
   input  logic                pd_dn,
   output logic [FDL_BITS-1:0] Q,
   output logic [FDL_BITS-1:0] Qb,
   output logic                lock,
   output logic                carry_up,
   output logic                carry_dn
);

   localparam int CNT_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam int LCNT_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC);
   localparam logic [LCNT_W-1:0] LCNT_MAX  = LCNT_W'(LOCK_CNT);

   fdl_state_t          state, state_nxt;
   logic [FDL_BITS-1:0] q_nxt;
   logic [IDX_W-1:0]    idx, idx_nxt;
   logic [CNT_W-1:0]    settle, settle_nxt;
   logic [LCNT_W-1:0]   lcnt, lcnt_nxt;
   logic                carry_up_nxt, carry_dn_nxt;
   logic                tracking, sample, filt_clr;
   logic                step_up, step_dn;

   assign tracking = (state == S_TRACK) || (state == S_LOCKED);
   // settle timer terminal count; the timer is reloaded after every sample,
   // so consecutive samples are SETTLE_CYC+1 cycles apart
   assign sample   = en && (state != S_IDLE) && (settle == '0);
   assign filt_clr = !en || !tracking;
   assign lock     = (state == S_LOCKED);

   fdl_step_filter #(.FILT(FILT)) u_filt (
      .clk_in  (clk_in),
      .rst     (rst),
      .clr     (filt_clr),
      .sample  (sample && tracking),
      .up      (pd_up),
      .dn      (pd_dn),
      .step_up (step_up),
      .step_dn (step_dn)
   );

   always_comb begin
      state_nxt    = state;
      q_nxt        = Q;
      idx_nxt      = idx;
      settle_nxt   = settle;
      lcnt_nxt     = lcnt;
      carry_up_nxt = 1'b0;
      carry_dn_nxt = 1'b0;
      if (!en) begin
         state_nxt  = S_IDLE;
         idx_nxt    = '0;
         settle_nxt = '0;
         lcnt_nxt   = '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state_nxt  = S_SAR;
               q_nxt      = Q_SAR_INIT;
               idx_nxt    = IDX_W'(FDL_BITS - 1);
               settle_nxt = SETTLE_LD;
            end
            S_SAR: begin
               if (sample) begin
                  settle_nxt = SETTLE_LD;
                  q_nxt      = sar_next(Q, idx, pd_up && !pd_dn);
                  if (idx == '0) begin
                     state_nxt = S_TRACK;
                     lcnt_nxt  = '0;
                  end else begin
                     idx_nxt = idx - 1'b1;
                  end
               end else begin
                  settle_nxt = settle - 1'b1;
               end
            end
            default: begin
               if (sample) begin
                  settle_nxt = SETTLE_LD;
                  if (step_up || step_dn) begin
                     state_nxt = S_TRACK;
                     lcnt_nxt  = '0;
                     // saturated ends never wrap; hand the step to the coarse stage
                     if (step_up) begin
                        if (Q == Q_MAX) carry_up_nxt = 1'b1;
                        else            q_nxt = Q + 1'b1;
                     end else begin
                        if (Q == '0) carry_dn_nxt = 1'b1;
                        else         q_nxt = Q - 1'b1;
                     end
                  end else begin
                     if (lcnt != LCNT_MAX) lcnt_nxt = lcnt + 1'b1;
                     if (lcnt_nxt == LCNT_MAX) state_nxt = S_LOCKED;
                  end
               end else begin
                  settle_nxt = settle - 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state    <= S_IDLE;
         Q        <= '0;
         Qb       <= '1;
         idx      <= '0;
         settle   <= '0;
         lcnt     <= '0;
         carry_up <= 1'b0;
         carry_dn <= 1'b0;
      end else begin
         state    <= state_nxt;
         Q        <= q_nxt;
         Qb       <= ~q_nxt;
         idx      <= idx_nxt;
         settle   <= settle_nxt;
         lcnt     <= lcnt_nxt;
         carry_up <= carry_up_nxt;
         carry_dn <= carry_dn_nxt;
      end
   end

endmodule
